alu_result_rx: RTL and testbench
================================

ALU_RESULT_RX -- requirements
Module: alu_result_rx

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter FAULT_THRESH, default 3, consecutive bad words that trigger the FAULT state.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a result word is presented this cycle.
REQ-006 in_ready  output  1  the receiver accepts the word this cycle.
REQ-007 in_y  input  8  ALU result bus.
REQ-008 in_parity  input  1  even-parity bit, equal to XOR of in_y[5:0].
REQ-009 in_greater, in_is_eq, in_less  input  1 each  compare flags, exactly one set.
REQ-010 out_valid  output  1  head FIFO entry available.
REQ-011 out_ready  input  1  consumer takes the head entry.
REQ-012 out_data  output  8  head entry result.
REQ-013 out_cmp  output  2  head compare code: 00 less, 01 eq, 10 greater, 11 invalid.
REQ-014 out_err  output  1  head entry failed a check.
REQ-015 clr  input  1  synchronous clear of counters, sticky status and FAULT.
REQ-016 par_err_cnt, flag_err_cnt, drop_cnt  output  8 each  saturating event counters.
REQ-017 fault  output  1  receiver is in FAULT.

Function
REQ-018 A transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-019 in_ready is high only in state RUN and when the FIFO is not full, and depends on registered state only.
REQ-020 Parity error: in_parity != XOR(in_y[5:0]); bits 6 and 7 are excluded from the check.
REQ-021 Flag error: the count of set compare flags is not exactly one; the stored out_cmp is 11.
REQ-022 Each accepted word is written to the FIFO with err = parity error OR flag error.
REQ-023 The FIFO is first-word-fall-through: out_valid rises the cycle after the first write, with a write-to-read latency of 1 cycle.
REQ-024 On a simultaneous push and pop while full, the pop frees the slot, but in_ready was already low, so no push occurs.
REQ-025 On a simultaneous push and pop while the FIFO holds 1 entry, occupancy stays 1 and the data stays ordered.
REQ-026 Pointers wrap modulo DEPTH; the full/empty decision uses an extra pointer bit.
REQ-027 drop_cnt increments when in_valid is high and in_ready is low in RUN state.
REQ-028 par_err_cnt and flag_err_cnt each increment once per accepted word carrying that error; a word carrying both increments both.
REQ-029 All counters saturate at 255.
REQ-030 FSM states:
  - IDLE: the cycle after reset.
  - RUN: entered from IDLE unconditionally.
  - FAULT: entered from RUN when the consecutive-bad count reaches FAULT_THRESH.
REQ-031 The consecutive-bad count increments on each accepted bad word, resets to 0 on each accepted good word, and holds when no transfer occurs.
REQ-032 In FAULT, in_ready is 0 and fault is 1; the FIFO still drains to the consumer; drop_cnt does not count.
REQ-033 When clr is asserted:
  - all three counters and the consecutive-bad count are zeroed;
  - FAULT goes to RUN on the next edge;
  - FIFO contents are preserved.
REQ-034 When clr coincides with an error event, clr wins and the counter reads 0.

Reset
REQ-035 While rst_n is low, the following apply immediately (asynchronously):
  - state IDLE, FIFO empty, pointers 0;
  - in_ready 0, out_valid 0, out_data 0, out_cmp 0, out_err 0;
  - all counters 0, fault 0.
REQ-036 Reset during operation discards FIFO contents; the first in_ready is high 2 edges after rst_n deasserts.

Structure
REQ-037 Package alu_rx_pkg holds:
  - the FSM state enum;
  - the cmp code constants (CMP_LT, CMP_EQ, CMP_GT, CMP_BAD);
  - the counter width constant 8.
REQ-038 The FIFO is one sub-module, alu_rx_fifo, parameterized by width 11 and DEPTH; the checks, counters and FSM live in the top.

Verification
REQ-039 Good word: in_y=0x2D, parity=0, is_eq=1 -> out_data 0x2D, out_cmp 01, out_err 0, all counters 0.
REQ-040 Parity error: in_y=0x01, parity=0, less=1 -> out_err 1, par_err_cnt 1; the same word with in_y=0xC0, parity=0 -> no error.
REQ-041 Fill with out_ready=0 and DEPTH=4: 6 consecutive valid words -> 4 stored, in_ready low, drop_cnt 2; then drain -> 4 words out in order.
REQ-042 Three consecutive words with flags 000 -> flag_err_cnt 3, fault 1, in_ready 0; then clr -> fault 0, counters 0, in_ready 1 the next cycle.
REQ-043 Saturation: 300 bad-parity words with FAULT_THRESH raised to 1000 -> par_err_cnt 255.
REQ-044 Reset asserted while 2 entries are stored -> out_valid 0 immediately; after release, in_ready 1 on the second edge.

Source files
------------

// File: rtl/alu_rx_pkg.sv
// Shared types and constants for the ALU result receiver.
package alu_rx_pkg;

    // Receiver operating modes
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } rx_state_e;

    // Compare codes stored alongside each result
    localparam logic [1:0] CMP_LT  = 2'b00;
    localparam logic [1:0] CMP_EQ  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_BAD = 2'b11;

    // Width of the event counters and of one stored FIFO entry {err, cmp, data}
    localparam int CNT_W   = 8;
    localparam int ENTRY_W = 11;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_rx_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on rdata
// the cycle after it is written. Pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits match.
module alu_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance each pointer by one when its side moves; wrap is natural
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers; reset empties the FIFO by realigning them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: stale slots are unreachable once pointers realign
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/alu_result_rx.sv
// Receives ALU result words, checks parity and compare flags, queues
// them for a consumer and tracks error statistics. A run of bad words
// parks the receiver in FAULT until software clears it.
module alu_result_rx
    import alu_rx_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FAULT_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_y,
    input  logic             in_parity,
    input  logic             in_greater,
    input  logic             in_is_eq,
    input  logic             in_less,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [1:0]       out_cmp,
    output logic             out_err,
    input  logic             clr,
    output logic [CNT_W-1:0] par_err_cnt,
    output logic [CNT_W-1:0] flag_err_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             fault
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              BAD_W    = 16;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [BAD_W-1:0] THRESH_V = BAD_W'(FAULT_THRESH);

    rx_state_e          state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0]   flag_cnt_q, flag_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;

    logic               push;
    logic               pop;
    logic               par_err;
    logic               flag_err;
    logic [1:0]         flag_sum;
    logic [1:0]         cmp_code;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_empty;
    logic               fifo_full;
    logic [AW:0]        fifo_count;
    logic [AW:0]        count_next;

    assign push      = in_valid && in_ready_q;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Word checks: parity covers bits 5:0 only, flags must be one-hot
    always_comb begin
        par_err  = (^in_y[5:0]) != in_parity;
        flag_sum = {1'b0, in_greater} + {1'b0, in_is_eq} + {1'b0, in_less};
        flag_err = (flag_sum != 2'd1);
        if (flag_err) begin
            cmp_code = CMP_BAD;
        end else if (in_greater) begin
            cmp_code = CMP_GT;
        end else if (in_is_eq) begin
            cmp_code = CMP_EQ;
        end else begin
            cmp_code = CMP_LT;
        end
        fifo_wdata = {par_err || flag_err, cmp_code, in_y};
    end

    alu_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Head entry is driven to zero whenever nothing is queued
    always_comb begin
        out_data = out_valid ? fifo_rdata[7:0]  : 8'h00;
        out_cmp  = out_valid ? fifo_rdata[9:8]  : 2'b00;
        out_err  = out_valid ? fifo_rdata[10]   : 1'b0;
    end

    // Next-state for counters, bad-run length, mode and the ready flag
    always_comb begin
        par_cnt_d  = par_cnt_q;
        flag_cnt_d = flag_cnt_q;
        drop_cnt_d = drop_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        state_d    = state_q;

        if (clr) begin
            par_cnt_d  = '0;
            flag_cnt_d = '0;
            drop_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            if (push && par_err) begin
                par_cnt_d = sat_inc(par_cnt_q);
            end
            if (push && flag_err) begin
                flag_cnt_d = sat_inc(flag_cnt_q);
            end
            if (in_valid && !in_ready_q && state_q == ST_RUN) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
            if (push) begin
                if (par_err || flag_err) begin
                    if (bad_cnt_q != {BAD_W{1'b1}}) begin
                        bad_cnt_d = bad_cnt_q + BAD_W'(1);
                    end
                end else begin
                    bad_cnt_d = '0;
                end
            end
        end

        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   if (!clr && bad_cnt_d >= THRESH_V) state_d = ST_FAULT;
            ST_FAULT: if (clr) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        // Ready is held off for the first RUN cycle after IDLE, and
        // looks ahead at occupancy so it drops as the last slot fills
        count_next = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        in_ready_d = (state_d == ST_RUN) && (state_q != ST_IDLE) &&
                     (count_next < FULL_CNT);
        fault_d    = (state_d == ST_FAULT);
    end

    // Mode, registered outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            fault_q    <= 1'b0;
            par_cnt_q  <= '0;
            flag_cnt_q <= '0;
            drop_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            fault_q    <= fault_d;
            par_cnt_q  <= par_cnt_d;
            flag_cnt_q <= flag_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign fault        = fault_q;
    assign par_err_cnt  = par_cnt_q;
    assign flag_err_cnt = flag_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_rx.sv
// Testbench for alu_result_rx: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_alu_result_rx;

   localparam int DEPTH = 4;
   localparam int THRESH = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic [7:0] in_y = 8'h00;
   logic in_parity = 1'b0;
   logic in_greater = 1'b0;
   logic in_is_eq = 1'b0;
   logic in_less = 1'b0;
   logic out_ready = 1'b0;
   logic clr = 1'b0;
   logic in_ready, out_valid, out_err, fault;
   logic [7:0] out_data, par_err_cnt, flag_err_cnt, drop_cnt;
   logic [1:0] out_cmp;

   logic s_in_valid = 1'b0;
   logic [7:0] s_in_y = 8'h00;
   logic s_in_parity = 1'b0;
   logic s_out_ready = 1'b1;
   logic s_clr = 1'b0;
   logic s_in_ready, s_out_valid, s_out_err, s_fault;
   logic [7:0] s_out_data, s_par_err_cnt, s_flag_err_cnt, s_drop_cnt;
   logic [1:0] s_out_cmp;

   int unsigned nVec = 0;
   int unsigned nMiss = 0;
   bit chkEn = 1'b0;

   // Model state: queue of {err, cmp, data}, mode 0=idle 1=run 2=fault
   logic [10:0] mq[$];
   int mMode = 0;
   bit mReady = 1'b0;
   int mPar = 0, mFlag = 0, mDrop = 0, mBad = 0;

   always #5 clk = ~clk;

   alu_result_rx #(.DEPTH(DEPTH), .FAULT_THRESH(THRESH)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_parity(in_parity), .in_greater(in_greater),
      .in_is_eq(in_is_eq), .in_less(in_less), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_cmp(out_cmp),
      .out_err(out_err), .clr(clr), .par_err_cnt(par_err_cnt),
      .flag_err_cnt(flag_err_cnt), .drop_cnt(drop_cnt), .fault(fault)
   );

   alu_result_rx #(.DEPTH(DEPTH), .FAULT_THRESH(1000)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_y(s_in_y), .in_parity(s_in_parity), .in_greater(1'b0),
      .in_is_eq(1'b1), .in_less(1'b0), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_data(s_out_data), .out_cmp(s_out_cmp),
      .out_err(s_out_err), .clr(s_clr), .par_err_cnt(s_par_err_cnt),
      .flag_err_cnt(s_flag_err_cnt), .drop_cnt(s_drop_cnt), .fault(s_fault)
   );

   // Single comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs on the main DUT, return after the next falling edge
   task automatic applyStimulus(input bit v, input logic [7:0] y, input bit par,
                                input logic [2:0] gel, input bit ordy, input bit c);
      in_valid = v;
      in_y = y;
      in_parity = par;
      {in_greater, in_is_eq, in_less} = gel;
      out_ready = ordy;
      clr = c;
      @(negedge clk);
   endtask

   function automatic int satAdd(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Behavioural model: advances one transfer step per rising edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mMode = 0; mReady = 1'b0;
         mPar = 0; mFlag = 0; mDrop = 0; mBad = 0;
      end else begin
         automatic bit doPush = in_valid && mReady;
         automatic bit doPop = (mq.size() > 0) && out_ready;
         automatic int nFlags = int'(in_greater) + int'(in_is_eq) + int'(in_less);
         automatic bit pErr = ((^in_y[5:0]) != in_parity);
         automatic bit fErr = (nFlags != 1);
         automatic logic [1:0] code = fErr ? 2'b11 : in_greater ? 2'b10 : in_is_eq ? 2'b01 : 2'b00;
         automatic int oldMode = mMode;
         if (clr) begin
            mPar = 0; mFlag = 0; mDrop = 0; mBad = 0;
         end else begin
            if (doPush && pErr) mPar = satAdd(mPar);
            if (doPush && fErr) mFlag = satAdd(mFlag);
            if (in_valid && !mReady && oldMode == 1) mDrop = satAdd(mDrop);
            if (doPush) mBad = (pErr || fErr) ? mBad + 1 : 0;
         end
         if (oldMode == 0) mMode = 1;
         else if (oldMode == 1 && !clr && mBad >= THRESH) mMode = 2;
         else if (oldMode == 2 && clr) mMode = 1;
         if (doPop) void'(mq.pop_front());
         if (doPush) mq.push_back({pErr || fErr, code, in_y});
         mReady = (mMode == 1) && (oldMode != 0) && (mq.size() < DEPTH);
      end
   end

   function automatic logic [37:0] expVec();
      automatic logic [10:0] head = (mq.size() > 0) ? mq[0] : 11'h000;
      return {mReady, mq.size() > 0, head[7:0], head[9:8], head[10],
              8'(mPar), 8'(mFlag), 8'(mDrop), mMode == 2};
   endfunction

   // Whole-output comparison against the model on every falling edge
   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("cycle", {in_ready, out_valid, out_data, out_cmp, out_err,
                               par_err_cnt, flag_err_cnt, drop_cnt, fault}, expVec());
      end
   end

   // Hard stop if the sequence ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] y;
      #2 rst_n = 1'b0;
      #1 chkEn = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_counters", {par_err_cnt, flag_err_cnt, drop_cnt, fault}, 0);

      rst_n = 1'b1;
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);
      checkOutput("rel_ready_edge1", in_ready, 0);
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);
      checkOutput("rel_ready_edge2", in_ready, 1);

      // Good word 0x2D, parity 0, equal
      applyStimulus(1, 8'h2D, 0, 3'b010, 1, 0);
      checkOutput("good_data", out_data, 8'h2D);
      checkOutput("good_cmp", out_cmp, 2'b01);
      checkOutput("good_err", out_err, 0);
      checkOutput("good_cnts", {par_err_cnt, flag_err_cnt, drop_cnt}, 0);
      checkOutput("model_q_size", mq.size(), 1);

      // Parity error on bit 0, then bits 6/7 only which are unchecked
      applyStimulus(1, 8'h01, 0, 3'b001, 1, 0);
      checkOutput("perr_err", out_err, 1);
      checkOutput("perr_cmp", out_cmp, 2'b00);
      checkOutput("perr_cnt", par_err_cnt, 1);
      checkOutput("model_par", mPar, 1);
      applyStimulus(1, 8'hC0, 0, 3'b001, 1, 0);
      checkOutput("hibits_data", out_data, 8'hC0);
      checkOutput("hibits_err", out_err, 0);
      checkOutput("hibits_cnt", par_err_cnt, 1);
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);

      // Fill with consumer stalled: 4 stored, 2 dropped
      for (int i = 0; i < 6; i++) begin
         y = 8'h10 + 8'(i);
         applyStimulus(1, y, ^y[5:0], 3'b100, 0, 0);
      end
      checkOutput("fill_ready", in_ready, 0);
      checkOutput("fill_drop", drop_cnt, 2);
      checkOutput("fill_head", out_data, 8'h10);
      checkOutput("model_fill", mq.size(), 4);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);
         if (i < 3) checkOutput("drain_order", out_data, 8'h11 + 8'(i));
      end
      checkOutput("drain_empty", out_valid, 0);

      // Three flag errors in a row enter FAULT, clr recovers
      for (int i = 0; i < 3; i++) begin
         y = 8'h20 + 8'(i);
         applyStimulus(1, y, ^y[5:0], 3'b000, 1, 0);
      end
      checkOutput("fault_flag_cnt", flag_err_cnt, 3);
      checkOutput("fault_flag", fault, 1);
      checkOutput("fault_ready", in_ready, 0);
      checkOutput("fault_cmp", out_cmp, 2'b11);
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 1);
      checkOutput("clr_fault", fault, 0);
      checkOutput("clr_cnts", {par_err_cnt, flag_err_cnt, drop_cnt}, 0);
      checkOutput("clr_ready", in_ready, 1);
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);

      // Reset with two stored entries
      applyStimulus(1, 8'h33, 0, 3'b010, 0, 0);
      applyStimulus(1, 8'h34, 1, 3'b010, 0, 0);
      checkOutput("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", out_valid, 0);
      checkOutput("async_rst_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);
      checkOutput("rst2_ready_edge1", in_ready, 0);
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 0);
      checkOutput("rst2_ready_edge2", in_ready, 1);

      // Random traffic; the per-cycle compare does the checking
      for (int i = 0; i < 600; i++) begin
         automatic logic [2:0] gel;
         y = 8'($urandom);
         gel = ($urandom_range(0, 99) < 85) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
         applyStimulus($urandom_range(0, 99) < 70, y,
                       ($urandom_range(0, 99) < 90) ? ^y[5:0] : ~(^y[5:0]),
                       gel, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      end
      applyStimulus(0, 8'h00, 0, 3'b010, 1, 1);

      // Saturation on the high-threshold instance
      s_in_valid = 1'b1;
      s_out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         s_in_y = 8'($urandom);
         s_in_parity = ~(^s_in_y[5:0]);
         @(negedge clk);
      end
      s_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("sat_par_cnt", s_par_err_cnt, 255);
      checkOutput("sat_fault", s_fault, 0);
      checkOutput("sat_other_cnts", {s_flag_err_cnt, s_drop_cnt}, 0);

      chkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
